token_stream_engine: RTL
========================

TOKEN_STREAM_ENGINE -- requirements
Module: token_stream_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH 32 GLB word-address width; DATA_WIDTH 32 token/psum width; NUM_CH 4 read channels (weight, ifmap, bias, spare); LEN_WIDTH 16 per-channel word count; SKID_DEPTH 2 output buffer entries (min 2).
REQ-002 SHALL have ports (name direction width meaning):
 clk in 1 single clock;
 rst in 1 synchronous active-high reset;
 PASS_START in 1 one-cycle pass start;
 pass_ch_en in NUM_CH channel enable mask;
 pass_base in NUM_CH*ADDR_WIDTH per-channel GLB base, ch0 in LSBs;
 pass_len in NUM_CH*LEN_WIDTH per-channel word count, ch0 in LSBs;
 BASE_OPSUM in ADDR_WIDTH psum write base;
 pass_psum_len in LEN_WIDTH psum words expected;
 glb_read_addr out ADDR_WIDTH read address;
 glb_read_ready out 1 read request (RE);
 glb_read_data in DATA_WIDTH read data, valid exactly 1 cycle after request;
 glb_write_addr out ADDR_WIDTH write address;
 glb_write_data out DATA_WIDTH write data;
 glb_write_valid out 1 write pending;
 WEB out 1 active-low write enable;
 glb_write_ready in 1 GLB accepts write this cycle;
 token_data out DATA_WIDTH token to PE array;
 token_ch out $clog2(NUM_CH) channel of token_data;
 pe_valid out NUM_CH one-hot token valid;
 pe_ready in NUM_CH per-channel PE ready;
 pe_psum_data in DATA_WIDTH;
 pe_psum_valid in 1;
 pe_psum_ready out 1;
 busy out 1 pass in progress;
 pass_done out 1 one-cycle completion pulse.

Function
REQ-003 SHALL implement states IDLE, STREAM, DRAIN; IDLE->STREAM on PASS_START; STREAM->DRAIN when all read counters zero; DRAIN->IDLE when no read in flight, skid empty, psum counter zero, no write pending; pass_done=1 exactly on DRAIN->IDLE cycle.
REQ-004 SHALL latch pass_ch_en, pass_base, pass_len, BASE_OPSUM, pass_psum_len on the PASS_START cycle; disabled channels load remaining count 0.
REQ-005 SHALL ignore PASS_START when not IDLE; busy=1 in STREAM and DRAIN.
REQ-006 SHALL select per cycle the next channel with remaining>0 in round-robin order starting after the last-issued channel (pointer resets to NUM_CH-1, so ch0 first).
REQ-007 SHALL issue a read (glb_read_ready=1, glb_read_addr=base+issued_count) only when skid_count+inflight (after same-cycle pop) < SKID_DEPTH; one read max per cycle.
REQ-008 SHALL push glb_read_data with its channel tag into the skid FIFO the cycle after issue; FIFO SHALL never overflow.
REQ-009 SHALL present FIFO head on token_data/token_ch with pe_valid[token_ch]=1, others 0; pop on pe_valid&pe_ready; hold data stable while stalled.
REQ-010 SHALL sustain one token/cycle when the target pe_ready stays high.
REQ-011 SHALL assert pe_psum_ready when busy, psum remaining>0, and (!glb_write_valid or glb_write_ready).
REQ-012 SHALL, on psum handshake, register glb_write_addr=BASE_OPSUM+psum_count, glb_write_data=pe_psum_data, glb_write_valid=1, WEB=0 next cycle; hold until glb_write_ready; then WEB=1 unless new psum accepted.
REQ-013 SHALL run read streaming and psum writeback concurrently; addresses wrap modulo 2^ADDR_WIDTH.
REQ-014 SHALL treat all-zero lengths and zero psum_len as pass going STREAM->DRAIN->IDLE, pass_done 2 cycles after PASS_START.

Reset
REQ-015 rst SHALL force IDLE, FIFO empty, inflight cleared, counters 0, RR pointer NUM_CH-1; outputs: glb_read_ready 0, glb_write_valid 0, WEB 1, pe_valid 0, pe_psum_ready 0, busy 0, pass_done 0, addresses/data 0.
REQ-016 rst mid-pass SHALL discard in-flight read data and pending write; no pass_done.

Verification
REQ-017 ch_en=0111, len={4,4,2}, bases {0,64,128}, all ready=1 -> tokens ch0,1,2,0,1,2,0,1,0,1 from addrs 0,64,128,1,65,129,2,66,3,67; 10 tokens in 10 consecutive cycles.
REQ-018 Same pass, pe_ready[1]=0 for 5 cycles -> at most SKID_DEPTH reads outstanding, token_data held, no token lost or duplicated.
REQ-019 psum_len=4, BASE_OPSUM=192, pe_psum_data=ABCD1234 continuous, glb_write_ready toggling -> exactly 4 writes to 192..195 with WEB=0, pe_psum_ready low while write stalled.
REQ-020 All lengths 0 -> pass_done pulse 2 cycles after PASS_START, no GLB access.
REQ-021 rst asserted mid-stream then new pass -> no pass_done for aborted pass, new pass correct from its bases.
REQ-022 PASS_START while busy -> ignored, original pass completes unchanged.

Source files
------------

// File: rtl/token_stream_engine.sv
// token_stream_engine
//   Streams per-channel word runs out of the GLB into the PE array. It also
//   writes returned partial sums back to the GLB while the read stream runs.
//
//   Ports
//     clk, rst            single clock, synchronous active-high reset
//     PASS_START          one-cycle pass start (ignored unless idle)
//     pass_ch_en/base/len per-channel enable, GLB base, word count (ch0 in LSBs)
//     BASE_OPSUM          psum write base address
//     pass_psum_len       number of psum words to write back
//     glb_read_*          read request (ready = RE), data returns one cycle later
//     glb_write_*, WEB    registered write request, held until glb_write_ready
//     token_data/token_ch skid FIFO head
//     pe_valid            one-hot valid for that head
//     pe_ready            per-channel PE ready
//     pe_psum_*           psum handshake from the PE array
//     busy, pass_done     pass in progress / one-cycle completion pulse

// Per-channel read cursor: base, words remaining and words issued.
module tse_rd_ch #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  en,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  pending
);
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  rem_q, cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            base_q <= base;
            rem_q  <= en ? len : '0;
            cnt_q  <= '0;
        end else if (issue) begin
            rem_q  <= rem_q - 1'b1;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Address arithmetic wraps naturally at ADDR_WIDTH.
    assign addr    = base_q + ADDR_WIDTH'(cnt_q);
    assign pending = (rem_q != '0);
endmodule

module token_stream_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int SKID_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           PASS_START,
    input  logic [NUM_CH-1:0]              pass_ch_en,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   pass_base,
    input  logic [NUM_CH*LEN_WIDTH-1:0]    pass_len,
    input  logic [ADDR_WIDTH-1:0]          BASE_OPSUM,
    input  logic [LEN_WIDTH-1:0]           pass_psum_len,
    output logic [ADDR_WIDTH-1:0]          glb_read_addr,
    output logic                           glb_read_ready,
    input  logic [DATA_WIDTH-1:0]          glb_read_data,
    output logic [ADDR_WIDTH-1:0]          glb_write_addr,
    output logic [DATA_WIDTH-1:0]          glb_write_data,
    output logic                           glb_write_valid,
    output logic                           WEB,
    input  logic                           glb_write_ready,
    output logic [DATA_WIDTH-1:0]          token_data,
    output logic [$clog2(NUM_CH)-1:0]      token_ch,
    output logic [NUM_CH-1:0]              pe_valid,
    input  logic [NUM_CH-1:0]              pe_ready,
    input  logic [DATA_WIDTH-1:0]          pe_psum_data,
    input  logic                           pe_psum_valid,
    output logic                           pe_psum_ready,
    output logic                           busy,
    output logic                           pass_done
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic [DATA_WIDTH-1:0] data;
    } tok_t;

    state_t state;
    logic   start_acc;

    assign start_acc = PASS_START && (state == IDLE);
    assign busy      = (state != IDLE);

    // ---------------- per-channel read cursors ----------------
    logic [NUM_CH-1:0]                 ch_pend, ch_issue;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_addr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tse_rd_ch #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .load    (start_acc),
            .en      (pass_ch_en[g]),
            .issue   (ch_issue[g]),
            .base    (pass_base[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .len     (pass_len[g*LEN_WIDTH +: LEN_WIDTH]),
            .addr    (ch_addr[g]),
            .pending (ch_pend[g])
        );
    end

    // ---------------- round-robin select ----------------
    logic [CH_W-1:0] rr_ptr, sel_ch, idx;
    logic            sel_found;

    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!sel_found && ch_pend[idx]) begin
                sel_found = 1'b1;
                sel_ch    = idx;
            end
        end
    end

    // ---------------- skid FIFO + read issue ----------------
    tok_t              skid [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  skid_cnt;
    logic              rd_inflight;
    logic [CH_W-1:0]   rd_tag;
    logic              tok_pop, room, rd_issue;

    assign token_data = skid[rd_ptr].data;
    assign token_ch   = skid[rd_ptr].ch;
    assign tok_pop    = (skid_cnt != '0) && pe_ready[token_ch];

    // Slots still claimable once this cycle's pop leaves; the in-flight read
    // already owns one. This keeps the FIFO from overflowing and still lets
    // two entries sustain one token per cycle.
    assign room     = (int'(skid_cnt) + int'(rd_inflight) - int'(tok_pop)) < SKID_DEPTH;
    assign rd_issue = (state == STREAM) && sel_found && room;

    assign glb_read_ready = rd_issue;
    assign glb_read_addr  = rd_issue ? ch_addr[sel_ch] : '0;

    always_comb begin
        ch_issue = '0;
        for (int g = 0; g < NUM_CH; g++)
            ch_issue[g] = rd_issue && (sel_ch == CH_W'(g));
    end

    always_comb begin
        pe_valid = '0;
        if (skid_cnt != '0) pe_valid[token_ch] = 1'b1;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) skid[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            skid_cnt    <= '0;
            rd_inflight <= 1'b0;
            rd_tag      <= '0;
            rr_ptr      <= CH_W'(NUM_CH - 1);
        end else begin
            rd_inflight <= rd_issue;
            if (rd_issue) rd_tag <= sel_ch;
            // A new pass restarts arbitration at ch0.
            if (start_acc)     rr_ptr <= CH_W'(NUM_CH - 1);
            else if (rd_issue) rr_ptr <= sel_ch;
            // Read data is valid exactly one cycle after its request.
            if (rd_inflight) begin
                skid[wr_ptr] <= '{ch: rd_tag, data: glb_read_data};
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (tok_pop) rd_ptr <= ptr_inc(rd_ptr);
            skid_cnt <= skid_cnt + CNT_W'(rd_inflight) - CNT_W'(tok_pop);
        end
    end

    // ---------------- psum writeback + pass FSM ----------------
    logic [ADDR_WIDTH-1:0] opsum_base;
    logic [LEN_WIDTH-1:0]  psum_rem, psum_cnt;
    logic                  psum_hs, drain_ok;

    assign pe_psum_ready = busy && (psum_rem != '0) && (!glb_write_valid || glb_write_ready);
    assign psum_hs       = pe_psum_valid && pe_psum_ready;
    assign drain_ok      = !rd_inflight && (skid_cnt == '0) && (psum_rem == '0) && !glb_write_valid;
    assign pass_done     = (state == DRAIN) && drain_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            opsum_base      <= '0;
            psum_rem        <= '0;
            psum_cnt        <= '0;
            glb_write_addr  <= '0;
            glb_write_data  <= '0;
            glb_write_valid <= 1'b0;
            WEB             <= 1'b1;
        end else begin
            case (state)
                IDLE: if (start_acc) begin
                    state      <= STREAM;
                    opsum_base <= BASE_OPSUM;
                    psum_rem   <= pass_psum_len;
                    psum_cnt   <= '0;
                end
                STREAM: if (ch_pend == '0) state <= DRAIN;
                DRAIN:  if (drain_ok) state <= IDLE;
                default: state <= IDLE;
            endcase

            // A handshake only happens when the slot is empty or being freed.
            if (psum_hs) begin
                glb_write_addr  <= opsum_base + ADDR_WIDTH'(psum_cnt);
                glb_write_data  <= pe_psum_data;
                glb_write_valid <= 1'b1;
                WEB             <= 1'b0;
                psum_rem        <= psum_rem - 1'b1;
                psum_cnt        <= psum_cnt + 1'b1;
            end else if (glb_write_valid && glb_write_ready) begin
                glb_write_valid <= 1'b0;
                WEB             <= 1'b1;
            end
        end
    end
endmodule
